// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus field positions and trap FSM state encoding
// used by the trap sequencer and its redirect-target helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTAT,
    T_JUMP,
    R_MSTAT,
    R_JUMP
  } trap_state_t;

  // mstatus on trap entry: stash MIE into MPIE, disable interrupts, MPP = M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

  // mstatus on MRET: restore MIE from MPIE, set MPIE, MPP stays M (M-only hart).
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

endpackage

// File: rtl/trap_target.sv
// Trap redirect target from captured mtvec; vectored interrupt offsets are
// only added when built with TRAP_VECTORED_EN.
module trap_target
  import csr_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic [31:0]        mtvec,
  input  logic               is_irq,
  input  logic [CAUSE_W-1:0] cause,
  output logic [31:0]        target
);

  logic [31:0] base;
  assign base = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  always_comb begin
    target = base;
    if (is_irq && (mtvec[1:0] == 2'b01))
      target = base + (32'(cause) << 2);
  end
`else
  logic unused_vec;
  assign unused_vec = ^{is_irq, cause, mtvec[1:0]};
  assign target = base;
`endif

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer: serialises CSR updates over one write port
// then redirects fetch. Optional vectored interrupts via TRAP_VECTORED_EN.
module trap_sequencer
  import csr_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        exc_tval,
  input  logic               irq_pending,
  input  logic [CAUSE_W-1:0] irq_cause,
  input  logic [31:0]        cur_pc,
  input  logic               mret_req,
  input  logic [31:0]        mstatus_in,
  input  logic [31:0]        mtvec_in,
  input  logic [31:0]        mepc_in,
  output logic               csr_we,
  output logic [11:0]        csr_waddr,
  output logic [31:0]        csr_wdata,
  output logic               stall,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy
);

  trap_state_t state, state_nxt;

  logic [31:0] mepc_q, mcause_q, tval_q, mstat_q, mtvec_q, ret_pc_q;
  logic [31:0] trap_pc;
  logic        irq_ok, take_trap, accept;

  logic unused_in;
  assign unused_in = ^{exc_pc[1:0], cur_pc[1:0], mepc_in[1:0]};

  assign irq_ok    = irq_pending && mstatus_in[MSTATUS_MIE];
  assign take_trap = exc_valid || irq_ok;
  // Gated by rst_n so outputs stay quiet while reset is held.
  assign accept    = rst_n && (state == IDLE) && (take_trap || mret_req);

  assign busy  = (state != IDLE);
  assign stall = accept || busy;
  assign flush = accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mepc_q   <= '0;
      mcause_q <= '0;
      tval_q   <= '0;
      mstat_q  <= '0;
      mtvec_q  <= '0;
      ret_pc_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mstat_q  <= mstatus_in;
        mtvec_q  <= mtvec_in;
        ret_pc_q <= {mepc_in[31:2], 2'b00};
        if (exc_valid) begin
          mepc_q   <= {exc_pc[31:2], 2'b00};
          mcause_q <= 32'(exc_cause);
          tval_q   <= exc_tval;
        end else begin
          mepc_q   <= {cur_pc[31:2], 2'b00};
          mcause_q <= 32'h8000_0000 | 32'(irq_cause);
          tval_q   <= '0;
        end
      end
    end
  end

  trap_target #(.CAUSE_W(CAUSE_W)) u_target (
    .mtvec  (mtvec_q),
    .is_irq (mcause_q[31]),
    .cause  (mcause_q[CAUSE_W-1:0]),
    .target (trap_pc)
  );

  always_comb begin
    state_nxt      = state;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = take_trap ? W_MEPC : R_MSTAT;
      end
      W_MEPC: begin
        state_nxt = W_MCAUSE;
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = mepc_q;
      end
      W_MCAUSE: begin
        state_nxt = W_MTVAL;
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = mcause_q;
      end
      W_MTVAL: begin
        state_nxt = W_MSTAT;
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = tval_q;
      end
      W_MSTAT: begin
        state_nxt = T_JUMP;
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = trap_mstatus(mstat_q);
      end
      T_JUMP: begin
        state_nxt      = IDLE;
        redirect_valid = 1'b1;
        redirect_pc    = trap_pc;
      end
      R_MSTAT: begin
        state_nxt = R_JUMP;
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mret_mstatus(mstat_q);
      end
      R_JUMP: begin
        state_nxt      = IDLE;
        redirect_valid = 1'b1;
        redirect_pc    = ret_pc_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a per-cycle expected-output queue
// model plus directed scenarios with hand-computed literal expectations.
module tb_trap_sequencer;

  localparam int CAUSE_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               exc_valid;
  logic [CAUSE_W-1:0] exc_cause;
  logic [31:0]        exc_pc, exc_tval;
  logic               irq_pending;
  logic [CAUSE_W-1:0] irq_cause;
  logic [31:0]        cur_pc;
  logic               mret_req;
  logic [31:0]        mstatus_in, mtvec_in, mepc_in;
  logic               csr_we;
  logic [11:0]        csr_waddr;
  logic [31:0]        csr_wdata;
  logic               stall, flush, redirect_valid, busy;
  logic [31:0]        redirect_pc;

  trap_sequencer #(.CAUSE_W(CAUSE_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .irq_pending    (irq_pending),
    .irq_cause      (irq_cause),
    .cur_pc         (cur_pc),
    .mret_req       (mret_req),
    .mstatus_in     (mstatus_in),
    .mtvec_in       (mtvec_in),
    .mepc_in        (mepc_in),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One entry per busy cycle: what the CSR port and redirect must show.
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
  } step_t;

  step_t       q[$];
  step_t       s;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [11:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] rd_pc;
  int          rd_lat, rd_cnt, stall_cnt, flush_cnt;

  logic        m_acc, m_irq;
  logic [31:0] m_pc, m_cause, m_tval, m_tgt, m_mst;
  logic        e_flush, e_stall, e_busy, e_we, e_rv;
  logic [11:0] e_addr;
  logic [31:0] e_data, e_rpc;

  always @(negedge clk) begin
    cyc++;
    m_acc = 1'b0;
    if (q.size() == 0) begin
      m_acc   = rst_n && (exc_valid || (irq_pending && mstatus_in[3]) || mret_req);
      e_flush = m_acc;
      e_stall = m_acc;
      e_busy  = 1'b0;
      e_we    = 1'b0;
      e_addr  = '0;
      e_data  = '0;
      e_rv    = 1'b0;
      e_rpc   = '0;
    end else begin
      s       = q.pop_front();
      e_flush = 1'b0;
      e_stall = 1'b1;
      e_busy  = 1'b1;
      e_we    = s.we;
      e_addr  = s.addr;
      e_data  = s.data;
      e_rv    = s.rv;
      e_rpc   = s.rpc;
    end
    chk("flush", 32'(flush), 32'(e_flush));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("csr_we", 32'(csr_we), 32'(e_we));
    chk("csr_waddr", 32'(csr_waddr), 32'(e_addr));
    chk("csr_wdata", csr_wdata, e_data);
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("redirect_pc", redirect_pc, e_rpc);

    if (csr_we) begin
      log_addr.push_back(csr_waddr);
      log_data.push_back(csr_wdata);
    end
    if (redirect_valid) begin
      rd_pc  = redirect_pc;
      rd_lat = cyc - acc_cyc;
      rd_cnt++;
    end
    if (stall) stall_cnt++;
    if (flush) flush_cnt++;

    if (m_acc) begin
      acc_cyc = cyc;
      if (exc_valid || (irq_pending && mstatus_in[3])) begin
        m_irq   = !exc_valid;
        m_pc    = m_irq ? cur_pc : exc_pc;
        m_cause = m_irq ? (32'h8000_0000 | 32'(irq_cause)) : 32'(exc_cause);
        m_tval  = m_irq ? 32'h0 : exc_tval;
        m_mst   = (mstatus_in & ~32'h1888) | 32'h1800 | (mstatus_in[3] ? 32'h80 : 32'h0);
        m_tgt   = mtvec_in & ~32'h3;
`ifdef TRAP_VECTORED_EN
        if (m_irq && mtvec_in[1:0] == 2'b01) m_tgt = m_tgt + 4 * 32'(irq_cause);
`endif
        q.push_back({1'b1, 12'h341, m_pc & ~32'h3, 1'b0, 32'h0});
        q.push_back({1'b1, 12'h342, m_cause, 1'b0, 32'h0});
        q.push_back({1'b1, 12'h343, m_tval, 1'b0, 32'h0});
        q.push_back({1'b1, 12'h300, m_mst, 1'b0, 32'h0});
        q.push_back({1'b0, 12'h000, 32'h0, 1'b1, m_tgt});
      end else begin
        m_mst = (mstatus_in & ~32'h1888) | 32'h1880 | (mstatus_in[7] ? 32'h8 : 32'h0);
        q.push_back({1'b1, 12'h300, m_mst, 1'b0, 32'h0});
        q.push_back({1'b0, 12'h000, 32'h0, 1'b1, mepc_in & ~32'h3});
      end
    end
    if (!rst_n) q.delete();
  end

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    rd_pc     = '0;
    rd_lat    = -1;
    rd_cnt    = 0;
    stall_cnt = 0;
    flush_cnt = 0;
  endtask

  task automatic quiet_inputs();
    exc_valid   = 1'b0;
    exc_cause   = '0;
    exc_pc      = 32'h0;
    exc_tval    = 32'h0;
    irq_pending = 1'b0;
    irq_cause   = '0;
    cur_pc      = 32'h0;
    mret_req    = 1'b0;
    mstatus_in  = 32'h0;
    mtvec_in    = 32'h0;
    mepc_in     = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    clear_logs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_csr_we", 32'(csr_we), 32'h0);
    chk("reset_redirect", 32'(redirect_valid), 32'h0);

    // exception; inputs scrambled after accept to prove capture
    @(posedge clk); #1 clear_logs();
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    @(posedge clk); #1
    exc_valid = 1'b0; exc_pc = 32'hFFC; exc_tval = 32'h0; mstatus_in = 32'h0; mtvec_in = 32'h998;
    repeat (7) @(posedge clk); #2;
    chk("exc_nwrites", 32'(log_addr.size()), 32'd4);
    chk("exc_mepc_a", 32'(log_addr[0]), 32'h341);
    chk("exc_mepc_d", log_data[0], 32'h100);
    chk("exc_mcause_d", log_data[1], 32'h2);
    chk("exc_mtval_d", log_data[2], 32'hDEAD);
    chk("exc_mstat_a", 32'(log_addr[3]), 32'h300);
    chk("exc_mstat_d", log_data[3], 32'h1880);
    chk("exc_rpc", rd_pc, 32'h200);
    chk("exc_latency", 32'(rd_lat), 32'd5);
    quiet_inputs();

    // interrupt gated by MIE=0, then taken with MIE=1
    @(posedge clk); #1 clear_logs();
    irq_pending = 1'b1; irq_cause = 4'd7; mstatus_in = 32'h0; mtvec_in = 32'h200; cur_pc = 32'h44;
    repeat (3) @(posedge clk); #2;
    chk("gate_nwrites", 32'(log_addr.size()), 32'd0);
    chk("gate_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1 mstatus_in = 32'h8;
    @(posedge clk); #1 quiet_inputs();
    repeat (7) @(posedge clk); #2;
    chk("irq_mepc_d", log_data[0], 32'h44);
    chk("irq_mcause_d", log_data[1], 32'h8000_0007);
    chk("irq_mtval_d", log_data[2], 32'h0);
    chk("irq_mstat_d", log_data[3], 32'h1880);
    chk("irq_latency", 32'(rd_lat), 32'd5);

    // all three requests together, held through the busy window
    @(posedge clk); #1 clear_logs();
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h300; exc_tval = 32'h5;
    irq_pending = 1'b1; irq_cause = 4'd3; cur_pc = 32'h600;
    mret_req = 1'b1; mepc_in = 32'h500; mstatus_in = 32'h88; mtvec_in = 32'h200;
    repeat (6) @(posedge clk);
    #1 quiet_inputs();
    repeat (3) @(posedge clk); #2;
    chk("sim_nwrites", 32'(log_addr.size()), 32'd4);
    chk("sim_mepc_d", log_data[0], 32'h300);
    chk("sim_mcause_d", log_data[1], 32'h2);
    chk("sim_mstat_d", log_data[3], 32'h1880);
    chk("sim_redirects", 32'(rd_cnt), 32'd1);
    chk("sim_flushes", 32'(flush_cnt), 32'd1);
    chk("sim_rpc", rd_pc, 32'h200);

    // mret
    @(posedge clk); #1 clear_logs();
    mret_req = 1'b1; mstatus_in = 32'h80; mepc_in = 32'h123;
    @(posedge clk); #1 quiet_inputs();
    repeat (4) @(posedge clk); #2;
    chk("mret_nwrites", 32'(log_addr.size()), 32'd1);
    chk("mret_mstat_a", 32'(log_addr[0]), 32'h300);
    chk("mret_mstat_d", log_data[0], 32'h1888);
    chk("mret_rpc", rd_pc, 32'h120);
    chk("mret_latency", 32'(rd_lat), 32'd2);

    // mtvec mode 01: interrupt, then exception
    @(posedge clk); #1 clear_logs();
    irq_pending = 1'b1; irq_cause = 4'd7; mstatus_in = 32'h8; mtvec_in = 32'h201; cur_pc = 32'h40;
    @(posedge clk); #1 quiet_inputs();
    repeat (7) @(posedge clk); #2;
`ifdef TRAP_VECTORED_EN
    chk("vec_irq_rpc", rd_pc, 32'h21C);
`else
    chk("vec_irq_rpc", rd_pc, 32'h200);
`endif
    @(posedge clk); #1 clear_logs();
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h80; mstatus_in = 32'h8; mtvec_in = 32'h201;
    @(posedge clk); #1 quiet_inputs();
    repeat (7) @(posedge clk); #2;
    chk("vec_exc_rpc", rd_pc, 32'h200);

    // reset during W_MTVAL aborts the sequence
    @(posedge clk); #1 clear_logs();
    exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h80; exc_tval = 32'h11;
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    @(posedge clk); #1 quiet_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    chk("rst_busy_after", 32'(busy), 32'h0);
    chk("rst_we_after", 32'(csr_we), 32'h0);
    repeat (6) @(posedge clk); #2;
    chk("rst_nwrites", 32'(log_addr.size()), 32'd3);
    chk("rst_last_addr", 32'(log_addr[2]), 32'h343);
    chk("rst_redirects", 32'(rd_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter CAUSE_W, default 4: width of the exception/interrupt cause code.
REQ-002 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, reset). One clock; reset is synchronous and active-low.
REQ-003 SHALL have exc_valid (in, 1) and exc_cause (in, CAUSE_W): synchronous exception request and its code.
REQ-004 SHALL have exc_pc (in, 32) and exc_tval (in, 32): PC of the faulting instruction and its trap value.
REQ-005 SHALL have irq_pending (in, 1), irq_cause (in, CAUSE_W) and cur_pc (in, 32): an enabled interrupt is pending; cur_pc is the resume PC.
REQ-006 SHALL have mret_req (in, 1): an MRET instruction is retiring.
REQ-007 SHALL have mstatus_in, mtvec_in and mepc_in (in, 32 each): current CSR values.
REQ-008 SHALL have csr_we (out, 1), csr_waddr (out, 12) and csr_wdata (out, 32): single CSR write port.
REQ-009 SHALL have stall (out, 1), flush (out, 1), redirect_valid (out, 1), redirect_pc (out, 32) and busy (out, 1).

Function
REQ-010 SHALL implement these FSM states: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, T_JUMP, R_MSTAT, R_JUMP.
REQ-011 SHALL accept requests only in IDLE, with priority exception > interrupt > mret. An interrupt qualifies only when irq_pending=1 and mstatus_in[3]=1.
REQ-012 On accept, SHALL capture the following, and subsequent inputs SHALL NOT affect the sequence:
- mepc value: exc_pc for an exception, cur_pc for an interrupt.
- mcause value: bit31 set for an interrupt, low CAUSE_W bits = cause, remaining bits zero.
- tval value: exc_tval for an exception, 0 for an interrupt.
- mstatus_in, mtvec_in, and {mepc_in[31:2],2'b00}.
REQ-013 The trap path SHALL be IDLE -> W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTAT -> T_JUMP -> IDLE, one state per cycle.
REQ-014 In each W_* state, csr_we=1 for one cycle with the following address and data:
- W_MEPC: 0x341, captured PC with bits[1:0]=0.
- W_MCAUSE: 0x342, captured cause.
- W_MTVAL: 0x343, captured tval.
- W_MSTAT: 0x300, captured mstatus with MPIE(7) = old MIE(3), MIE(3)=0, MPP(12:11)=2'b11.
REQ-015 The mret path SHALL be IDLE -> R_MSTAT -> R_JUMP -> IDLE. R_MSTAT writes 0x300 with MIE = old MPIE, MPIE=1, MPP=2'b11.
REQ-016 In T_JUMP, redirect_valid=1 for one cycle with redirect_pc = {mtvec[31:2],2'b00} (direct mode, subject to REQ-024).
REQ-017 In R_JUMP, redirect_valid=1 for one cycle with redirect_pc = the captured mepc.
REQ-018 Cycle timing SHALL be:
- flush=1 combinationally in the accept cycle only.
- stall=1 in the accept cycle and in every non-IDLE state.
- busy=1 in every non-IDLE state.
- csr_we=0 in IDLE, T_JUMP and R_JUMP.
REQ-019 Trap latency from accept to redirect SHALL be exactly 5 cycles; mret latency SHALL be exactly 2 cycles.
REQ-020 Requests arriving while busy SHALL be ignored; the pipeline holds them under stall.
REQ-021 When csr_we=0, csr_waddr and csr_wdata SHALL be 0.

Reset
REQ-022 On a clock edge with rst_n=0, the state SHALL become IDLE, all captured registers SHALL become 0, and all outputs SHALL be 0 in the following cycle.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence with no further CSR writes or redirect.

Configuration
REQ-024 Macro TRAP_VECTORED_EN, when defined, SHALL enable vectored interrupts:
- Condition: captured mtvec[1:0]=2'b01 and the trap is an interrupt.
- Then redirect_pc = {mtvec[31:2],2'b00} + 4*cause.
- Exceptions SHALL always use the base address.
REQ-025 Without TRAP_VECTORED_EN, redirect_pc for every trap SHALL be {mtvec[31:2],2'b00}, regardless of mtvec[1:0].

Structure
REQ-026 A shared package csr_pkg SHALL hold:
- CSR addresses 0x300, 0x341, 0x342 and 0x343.
- mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
- The machine-mode constant 2'b11.
- The FSM state enum.
REQ-027 One sub-module, trap_target, SHALL compute redirect_pc combinationally from mtvec, the interrupt flag and the cause.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Exception: exc_valid, cause=2, exc_pc=0x100, tval=0xDEAD, mstatus=0x8 -> writes (0x341,0x100), (0x342,0x2), (0x343,0xDEAD), (0x300,0x1880); redirect at cycle 5 to mtvec base 0x200.
- Interrupt gating: irq_pending, cause=7, mstatus MIE=0 -> no accept, no stall. With MIE=1, cur_pc=0x44 -> mcause 0x80000007, mtval 0.
- Simultaneous exc_valid, irq_pending and mret_req -> exception path taken; the others are ignored while busy.
- MRET with mstatus=0x80, mepc=0x123 -> mstatus written 0x1888; redirect_pc=0x120 two cycles after accept.
- TRAP_VECTORED_EN, mtvec=0x201, interrupt cause 7 -> redirect 0x21C. Same setup with an exception cause 2 -> 0x200. Without the macro, the interrupt case -> 0x200.
- rst_n=0 during W_MTVAL -> no W_MSTAT write, no redirect, IDLE next cycle.
